// File: rtl/eq_band_sequencer.sv
// Sequencer for a cascaded Biquad peaking-EQ chain: strobes each band once per
// sample in cascade order and serialises queued gain updates between passes.
module eq_band_sequencer #(
    parameter int N_BANDS    = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int SET_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_sample_valid,
    input  logic [31:0]        i_sample,
    input  logic               i_gain_valid,
    input  logic [2:0]         i_gain_band,
    input  logic [15:0]        i_gain_value,
    input  logic               i_clr_overrun,
    output logic               o_gain_ready,
    output logic [N_BANDS-1:0] o_set,
    output logic [15:0]        o_gain,
    output logic [N_BANDS-1:0] o_next,
    output logic [31:0]        o_data,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_overrun
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
    localparam int WW = $clog2(SET_CYCLES);
    localparam logic [N_BANDS-1:0] W_ONE = N_BANDS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SET
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_bandCnt;
    logic          r_phase;
    logic [WW-1:0] r_waitCnt;
    logic          r_pendValid;
    logic [31:0]   r_pendData;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [2:0]    r_fifoBand  [FIFO_DEPTH];
    logic [15:0]   r_fifoValue [FIFO_DEPTH];

    logic          w_push;
    logic          w_pop;
    logic          w_fifoEmpty;
    logic          w_entryAvail;
    logic [2:0]    w_headBand;
    logic [15:0]   w_headValue;
    logic          w_setLast;
    logic          w_sampleGo;
    logic [31:0]   w_startData;
    logic          w_sampleDrop;
    logic [CW-1:0] w_countNext;

    // An empty FIFO forwards the arriving request so it can pop the same cycle.
    always_comb begin
        w_push       = i_gain_valid && o_gain_ready;
        w_fifoEmpty  = (r_count == '0);
        w_entryAvail = !w_fifoEmpty || w_push;
        w_headBand   = w_fifoEmpty ? i_gain_band  : r_fifoBand[r_rdPtr];
        w_headValue  = w_fifoEmpty ? i_gain_value : r_fifoValue[r_rdPtr];
        w_setLast    = (r_state == S_SET) && (r_waitCnt == WW'(SET_CYCLES - 1));
        w_sampleGo   = ((r_state == S_IDLE) && (i_sample_valid || r_pendValid)) ||
                       (w_setLast && (r_pendValid || i_sample_valid));
        w_startData  = r_pendValid ? r_pendData : i_sample;
        w_pop        = !w_sampleGo && w_entryAvail &&
                       ((r_state == S_IDLE) || w_setLast);
        w_sampleDrop = i_sample_valid &&
                       ((r_state == S_RUN) || ((r_state == S_SET) && r_pendValid));
        w_countNext  = r_count;
        if (w_push && !w_pop) begin
            w_countNext = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifoBand[r_wrPtr]  <= i_gain_band;
            r_fifoValue[r_wrPtr] <= i_gain_value;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_bandCnt    <= '0;
            r_phase      <= 1'b0;
            r_waitCnt    <= '0;
            r_pendValid  <= 1'b0;
            r_pendData   <= '0;
            r_count      <= '0;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            o_gain_ready <= 1'b1;
            o_set        <= '0;
            o_gain       <= '0;
            o_next       <= '0;
            o_data       <= '0;
            o_done       <= 1'b0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_set        <= '0;
            o_done       <= 1'b0;
            r_count      <= w_countNext;
            o_gain_ready <= (w_countNext != CW'(FIFO_DEPTH));

            if (w_push) begin
                r_wrPtr <= (r_wrPtr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
            end

            // A new drop outranks a clear in the same cycle.
            if (w_sampleDrop) begin
                o_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                o_overrun <= 1'b0;
            end

            if (w_sampleGo) begin
                r_pendValid <= 1'b0;
            end else if ((r_state == S_SET) && i_sample_valid && !r_pendValid) begin
                r_pendValid <= 1'b1;
                r_pendData  <= i_sample;
            end

            if (w_sampleGo) begin
                r_state   <= S_RUN;
                r_bandCnt <= '0;
                r_phase   <= 1'b0;
                o_data    <= w_startData;
                o_next    <= W_ONE;
                o_busy    <= 1'b1;
            end else if (w_pop) begin
                r_state   <= S_SET;
                r_waitCnt <= '0;
                o_next    <= '0;
                o_busy    <= 1'b1;
                if (int'(w_headBand) < N_BANDS) begin
                    o_set  <= W_ONE << w_headBand;
                    o_gain <= w_headValue;
                end
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            o_next  <= '0;
                        end else if (r_bandCnt == BW'(N_BANDS - 1)) begin
                            r_state <= S_IDLE;
                            o_next  <= '0;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                        end else begin
                            r_bandCnt <= r_bandCnt + 1'b1;
                            r_phase   <= 1'b0;
                            o_next    <= W_ONE << (r_bandCnt + 1'b1);
                        end
                    end
                    S_SET: begin
                        if (w_setLast) begin
                            r_state <= S_IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            r_waitCnt <= r_waitCnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        o_next  <= '0;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eq_band_sequencer.sv
// Scoreboard bench for eq_band_sequencer: expected strobes are queued with
// their cycle numbers when stimulus is driven and matched as the DUT emits them.
module tb_eq_band_sequencer;
    localparam int N_BANDS    = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int SET_CYCLES = 4;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_sample_valid;
    logic [31:0]        i_sample;
    logic               i_gain_valid;
    logic [2:0]         i_gain_band;
    logic [15:0]        i_gain_value;
    logic               i_clr_overrun;
    logic               o_gain_ready;
    logic [N_BANDS-1:0] o_set;
    logic [15:0]        o_gain;
    logic [N_BANDS-1:0] o_next;
    logic [31:0]        o_data;
    logic               o_done;
    logic               o_busy;
    logic               o_overrun;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t nextQ[$];
    exp_t setQ[$];
    exp_t doneQ[$];
    int   cyc;
    int   checks;
    int   failures;
    int   b;

    eq_band_sequencer #(
        .N_BANDS(N_BANDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .SET_CYCLES(SET_CYCLES)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_sample_valid(i_sample_valid),
        .i_sample(i_sample),
        .i_gain_valid(i_gain_valid),
        .i_gain_band(i_gain_band),
        .i_gain_value(i_gain_value),
        .i_clr_overrun(i_clr_overrun),
        .o_gain_ready(o_gain_ready),
        .o_set(o_set),
        .o_gain(o_gain),
        .o_next(o_next),
        .o_data(o_data),
        .o_done(o_done),
        .o_busy(o_busy),
        .o_overrun(o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Drives one cycle of inputs starting just after a rising edge.
    task automatic applyStimulus(input logic sv, input logic [31:0] smp, input logic gv,
                                 input logic [2:0] band, input logic [15:0] val,
                                 input logic clr);
        i_sample_valid = sv;
        i_sample       = smp;
        i_gain_valid   = gv;
        i_gain_band    = band;
        i_gain_value   = val;
        i_clr_overrun  = clr;
        @(posedge i_clk);
        #1;
        i_sample_valid = 1'b0;
        i_sample       = '0;
        i_gain_valid   = 1'b0;
        i_gain_band    = '0;
        i_gain_value   = '0;
        i_clr_overrun  = 1'b0;
    endtask

    task automatic toPos(input int c);
        while (cyc < c) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic toNeg(input int c);
        @(negedge i_clk);
        while (cyc < c) @(negedge i_clk);
    endtask

    task automatic expectPass(input int start, input logic [31:0] data);
        exp_t        e;
        logic [31:0] one;
        one = 32'd1;
        for (int k = 0; k < N_BANDS; k++) begin
            e.cyc = start + 1 + 2 * k;
            e.val = one << k;
            nextQ.push_back(e);
        end
        e.cyc = start + 2 * N_BANDS + 1;
        e.val = data;
        doneQ.push_back(e);
    endtask

    task automatic expectSet(input int c, input logic [2:0] band, input logic [15:0] value);
        exp_t        e;
        logic [15:0] oh;
        oh    = 16'd1 << band;
        e.cyc = c;
        e.val = {value, oh};
        setQ.push_back(e);
    endtask

    // Every strobe the DUT emits must match the head of its queue.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (o_next != '0) begin
            if (nextQ.size() == 0) begin
                checkOutput("next_extra", 32'(o_next), 32'd0);
            end else begin
                e = nextQ.pop_front();
                checkOutput("next_cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("next_value", 32'(o_next), e.val);
            end
        end
        if (o_set != '0) begin
            if (setQ.size() == 0) begin
                checkOutput("set_extra", 32'(o_set), 32'd0);
            end else begin
                e = setQ.pop_front();
                checkOutput("set_cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("set_value", {o_gain, 16'(o_set)}, e.val);
            end
        end
        if (o_done) begin
            if (doneQ.size() == 0) begin
                checkOutput("done_extra", 32'(o_done), 32'd0);
            end else begin
                e = doneQ.pop_front();
                checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("done_data", o_data, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        i_rst_n        = 1'b0;
        i_sample_valid = 1'b0;
        i_sample       = '0;
        i_gain_valid   = 1'b0;
        i_gain_band    = '0;
        i_gain_value   = '0;
        i_clr_overrun  = 1'b0;

        toNeg(2);
        checkOutput("rst_next", 32'(o_next), 32'd0);
        checkOutput("rst_set", 32'(o_set), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_ready", 32'(o_gain_ready), 32'd1);
        checkOutput("rst_data", o_data, 32'd0);
        checkOutput("rst_ovr", 32'(o_overrun), 32'd0);
        toPos(3);
        i_rst_n = 1'b1;

        // Single sample pass
        toPos(5);
        b = cyc;
        expectPass(b, 32'h0000_8000);
        applyStimulus(1'b1, 32'h0000_8000, 1'b0, 3'd0, 16'd0, 1'b0);
        toNeg(b + 1);
        checkOutput("t1_data", o_data, 32'h0000_8000);
        checkOutput("t1_busy1", 32'(o_busy), 32'd1);
        toNeg(b + 10);
        checkOutput("t1_busy10", 32'(o_busy), 32'd1);
        toNeg(b + 11);
        checkOutput("t1_busy11", 32'(o_busy), 32'd0);
        checkOutput("t1_ovr", 32'(o_overrun), 32'd0);

        // Gain request in idle
        toPos(b + 14);
        b = cyc;
        expectSet(b + 1, 3'd2, 16'hFFFA);
        applyStimulus(1'b0, 32'd0, 1'b1, 3'd2, 16'hFFFA, 1'b0);
        toNeg(b + 1);
        checkOutput("t2_busy1", 32'(o_busy), 32'd1);
        toNeg(b + 4);
        checkOutput("t2_busy4", 32'(o_busy), 32'd1);
        checkOutput("t2_gain", 32'(o_gain), 32'h0000_FFFA);
        toNeg(b + 5);
        checkOutput("t2_busy5", 32'(o_busy), 32'd0);

        // Sample held pending during a coefficient update
        toPos(b + 7);
        b = cyc;
        expectSet(b + 1, 3'd1, 16'h0003);
        expectPass(b + 4, 32'h0000_1234);
        applyStimulus(1'b0, 32'd0, 1'b1, 3'd1, 16'h0003, 1'b0);
        toPos(b + 2);
        applyStimulus(1'b1, 32'h0000_1234, 1'b0, 3'd0, 16'd0, 1'b0);
        toNeg(b + 4);
        checkOutput("t3_ovr", 32'(o_overrun), 32'd0);
        toNeg(b + 5);
        checkOutput("t3_data", o_data, 32'h0000_1234);

        // Second sample in the same update is dropped
        toPos(b + 17);
        b = cyc;
        expectSet(b + 1, 3'd4, 16'h0009);
        expectPass(b + 4, 32'h0000_AAAA);
        applyStimulus(1'b0, 32'd0, 1'b1, 3'd4, 16'h0009, 1'b0);
        toPos(b + 2);
        applyStimulus(1'b1, 32'h0000_AAAA, 1'b0, 3'd0, 16'd0, 1'b0);
        applyStimulus(1'b1, 32'h0000_BBBB, 1'b0, 3'd0, 16'd0, 1'b0);
        toNeg(b + 4);
        checkOutput("t3b_ovr", 32'(o_overrun), 32'd1);
        toNeg(b + 6);
        checkOutput("t3b_data", o_data, 32'h0000_AAAA);
        toPos(b + 17);
        applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        toNeg(b + 18);
        checkOutput("t3b_clr", 32'(o_overrun), 32'd0);

        // Drop in the last run cycle; next cycle accepted
        toPos(b + 20);
        b = cyc;
        expectPass(b, 32'h0000_0011);
        expectPass(b + 11, 32'h0000_0033);
        applyStimulus(1'b1, 32'h0000_0011, 1'b0, 3'd0, 16'd0, 1'b0);
        toPos(b + 10);
        applyStimulus(1'b1, 32'h0000_0022, 1'b0, 3'd0, 16'd0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0033, 1'b0, 3'd0, 16'd0, 1'b0);
        toNeg(b + 12);
        checkOutput("t4_ovr", 32'(o_overrun), 32'd1);
        toPos(b + 13);
        applyStimulus(1'b1, 32'h0000_0044, 1'b0, 3'd0, 16'd0, 1'b1);
        toNeg(b + 14);
        checkOutput("t4_setwins", 32'(o_overrun), 32'd1);
        toPos(b + 23);
        applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 16'd0, 1'b1);
        toNeg(b + 24);
        checkOutput("t4_clr", 32'(o_overrun), 32'd0);

        // FIFO fills during a pass; fifth request refused
        toPos(b + 26);
        b = cyc;
        expectPass(b, 32'h0000_0055);
        expectSet(b + 12, 3'd0, 16'h0101);
        expectSet(b + 16, 3'd1, 16'h0202);
        expectSet(b + 20, 3'd3, 16'h0303);
        expectSet(b + 24, 3'd4, 16'h0404);
        applyStimulus(1'b1, 32'h0000_0055, 1'b0, 3'd0, 16'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 3'd0, 16'h0101, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 3'd1, 16'h0202, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 3'd3, 16'h0303, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 3'd4, 16'h0404, 1'b0);
        checkOutput("t5_full", 32'(o_gain_ready), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 3'd0, 16'h0505, 1'b0);
        toNeg(b + 12);
        checkOutput("t5_ready", 32'(o_gain_ready), 32'd1);
        toNeg(b + 30);
        checkOutput("t5_idle", 32'(o_busy), 32'd0);

        // Out-of-range band consumes an update slot without a strobe
        toPos(b + 32);
        b = cyc;
        expectSet(b + 5, 3'd3, 16'h0007);
        applyStimulus(1'b0, 32'd0, 1'b1, 3'd6, 16'h0606, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 3'd3, 16'h0007, 1'b0);
        toNeg(b + 1);
        checkOutput("t6_noset", 32'(o_set), 32'd0);
        checkOutput("t6_busy1", 32'(o_busy), 32'd1);
        toNeg(b + 4);
        checkOutput("t6_busy4", 32'(o_busy), 32'd1);
        toNeg(b + 10);
        checkOutput("t6_idle", 32'(o_busy), 32'd0);

        // Reset mid-pass aborts the chain
        toPos(b + 12);
        b = cyc;
        begin
            exp_t e;
            e.cyc = b + 1;
            e.val = 32'd1;
            nextQ.push_back(e);
            e.cyc = b + 3;
            e.val = 32'd2;
            nextQ.push_back(e);
        end
        applyStimulus(1'b1, 32'h0000_7777, 1'b0, 3'd0, 16'd0, 1'b0);
        toPos(b + 4);
        i_rst_n = 1'b0;
        #1;
        checkOutput("t7_next", 32'(o_next), 32'd0);
        checkOutput("t7_busy", 32'(o_busy), 32'd0);
        checkOutput("t7_data", o_data, 32'd0);
        checkOutput("t7_gain", 32'(o_gain), 32'd0);
        checkOutput("t7_ready", 32'(o_gain_ready), 32'd1);
        toPos(b + 6);
        i_rst_n = 1'b1;
        toNeg(b + 30);
        checkOutput("t7_idle", 32'(o_busy), 32'd0);

        checkOutput("next_left", 32'(nextQ.size()), 32'd0);
        checkOutput("set_left", 32'(setQ.size()), 32'd0);
        checkOutput("done_left", 32'(doneQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
